// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use bubble, branch flush, memory-wait hold.
// Optional performance counters are built when HCU_PERF_CNT_EN is defined.
module hazard_control_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             ex_wr,
    input  logic             mem_wr,
    input  logic             wb_wr,
    input  logic             ex_is_load,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic             cu_mux_select,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             pipe_hold
`ifdef HCU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [REG_W-1:0] PC_IDX = REG_W'(15);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t state;
    state_t saved;
    state_t eff;

    logic [1:0] fa, fb, fc;
    logic [2:0] src_hit;
    logic       lu_hazard;
    logic       mux, pc, ifid, flush, hold, bubble;

    // Youngest producer wins; the PC is read directly and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic             use_src,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] e_rd,
        input logic             e_wr,
        input logic [REG_W-1:0] m_rd,
        input logic             m_wr,
        input logic [REG_W-1:0] w_rd,
        input logic             w_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && src != PC_IDX) begin
            if (e_wr && src == e_rd)      sel = 2'b01;
            else if (m_wr && src == m_rd) sel = 2'b10;
            else if (w_wr && src == w_rd) sel = 2'b11;
        end
        return sel;
    endfunction

    assign fa = fwd_sel(id_use_rn, id_rn, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
    assign fb = fwd_sel(id_use_rm, id_rm, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
    assign fc = fwd_sel(id_use_rd, id_rd, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);

    assign src_hit[0] = id_use_rn && id_rn == ex_rd && id_rn != PC_IDX;
    assign src_hit[1] = id_use_rm && id_rm == ex_rd && id_rm != PC_IDX;
    assign src_hit[2] = id_use_rd && id_rd == ex_rd && id_rd != PC_IDX;
    assign lu_hazard  = ex_is_load && ex_wr && (|src_hit);

    // Once mem_wait drops, behave exactly as the state that was interrupted.
    assign eff = (state == HOLD) ? saved : state;

    always_comb begin
        mux    = 1'b1;
        pc     = 1'b1;
        ifid   = 1'b1;
        flush  = 1'b0;
        hold   = 1'b0;
        bubble = 1'b0;
        if (mem_wait) begin
            hold = 1'b1;
            pc   = 1'b0;
            ifid = 1'b0;
        end else if (branch_taken) begin
            flush = 1'b1;
            mux   = 1'b0;
        end else if (eff == RUN && lu_hazard) begin
            mux    = 1'b0;
            pc     = 1'b0;
            ifid   = 1'b0;
            bubble = 1'b1;
        end
    end

    // Reset forces the pass-through values straight away, independent of the clock.
    assign fwd_a         = rst_n ? fa : 2'b00;
    assign fwd_b         = rst_n ? fb : 2'b00;
    assign fwd_c         = rst_n ? fc : 2'b00;
    assign cu_mux_select = !rst_n || mux;
    assign pc_enable     = !rst_n || pc;
    assign if_id_enable  = !rst_n || ifid;
    assign if_id_flush   = rst_n && flush;
    assign pipe_hold     = rst_n && hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            saved <= RUN;
        end else if (mem_wait) begin
            state <= HOLD;
            saved <= eff;
        end else begin
            saved <= RUN;
            state <= bubble ? LU_BUBBLE : RUN;
        end
    end

`ifdef HCU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (bubble && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
            if (!mem_wait && branch_taken && flush_count != {CNT_W{1'b1}})
                flush_count <= flush_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus randomized cycles against a behavioural model.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd;
    logic       id_use_rn, id_use_rm, id_use_rd;
    logic       ex_wr, mem_wr, wb_wr, ex_is_load, branch_taken, mem_wait;
    logic [1:0] fwd_a, fwd_b, fwd_c;
    logic       cu_mux_select, pc_enable, if_id_enable, if_id_flush, pipe_hold;
`ifdef HCU_PERF_CNT_EN
    logic [15:0] stall_count, flush_count;
    int          exp_stall, exp_flush;
`endif

    int checks = 0;
    int failures = 0;
    bit last_bubble;  // model: previous non-held cycle issued a load-use bubble

    logic [10:0] obs;
    logic [10:0] exp_v;
    assign obs = {fwd_a, fwd_b, fwd_c, cu_mux_select, pc_enable, if_id_enable, if_id_flush, pipe_hold};

    localparam logic [10:0] IDLE = 11'b00_00_00_1_1_1_0_0;

    hazard_control_unit dut (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .ex_is_load(ex_is_load), .branch_taken(branch_taken), .mem_wait(mem_wait),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
        .cu_mux_select(cu_mux_select), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .if_id_flush(if_id_flush), .pipe_hold(pipe_hold)
`ifdef HCU_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [10:0] ctl(logic [1:0] a, logic [1:0] b, logic [1:0] c,
                                        logic m, logic p, logic i, logic f, logic h);
        return {a, b, c, m, p, i, f, h};
    endfunction

    // Reference forwarding: scan producers youngest first.
    function automatic logic [1:0] ref_fwd(logic use_s, logic [3:0] src);
        logic [3:0] rds [3];
        logic       wrs [3];
        rds = '{ex_rd, mem_rd, wb_rd};
        wrs = '{ex_wr, mem_wr, wb_wr};
        if (!use_s || src == 4'd15) return 2'd0;
        for (int s = 0; s < 3; s++)
            if (wrs[s] && rds[s] == src) return 2'(s + 1);
        return 2'd0;
    endfunction

    function automatic bit ref_hazard();
        bit hit;
        hit = (id_use_rn && id_rn == ex_rd && id_rn != 4'd15) ||
              (id_use_rm && id_rm == ex_rd && id_rm != 4'd15) ||
              (id_use_rd && id_rd == ex_rd && id_rd != 4'd15);
        return ex_is_load && ex_wr && hit;
    endfunction

    function automatic logic [10:0] ref_outputs();
        logic [1:0] a, b, c;
        a = ref_fwd(id_use_rn, id_rn);
        b = ref_fwd(id_use_rm, id_rm);
        c = ref_fwd(id_use_rd, id_rd);
        if (mem_wait)                         return ctl(a, b, c, 1, 0, 0, 0, 1);
        if (branch_taken)                     return ctl(a, b, c, 0, 1, 1, 1, 0);
        if (ref_hazard() && !last_bubble)     return ctl(a, b, c, 0, 0, 0, 0, 0);
        return ctl(a, b, c, 1, 1, 1, 0, 0);
    endfunction

    task automatic clear_in();
        {id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rn, id_use_rm, id_use_rd, ex_wr, mem_wr, wb_wr} = '0;
        {ex_is_load, branch_taken, mem_wait} = '0;
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    task automatic rand_in();
        id_rn = rreg(); id_rm = rreg(); id_rd = rreg();
        ex_rd = rreg(); mem_rd = rreg(); wb_rd = rreg();
        id_use_rn = 1'($urandom); id_use_rm = 1'($urandom); id_use_rd = 1'($urandom);
        ex_wr = 1'($urandom); mem_wr = 1'($urandom); wb_wr = 1'($urandom);
        ex_is_load = 1'($urandom);
        branch_taken = ($urandom_range(0, 6) == 0);
        mem_wait = ($urandom_range(0, 4) == 0);
    endtask

    task automatic lu_in();
        clear_in();
        ex_is_load = 1; ex_wr = 1; ex_rd = 4'd2; id_rm = 4'd2; id_use_rm = 1;
    endtask

    task automatic mem_in();
        clear_in();
        mem_rd = 4'd2; mem_wr = 1; id_rm = 4'd2; id_use_rm = 1;
    endtask

    // One quiet cycle so every scenario starts from normal operation.
    task automatic settle();
        @(negedge clk);
        clear_in();
    endtask

    task automatic test_reset();
        rst_n = 0;
        lu_in();
        mem_wait = 1;
        #1;
        checks++;
        if (obs !== IDLE) begin failures++; $display("FAIL reset_hold: obs=%b exp=%b", obs, IDLE); end
        mem_wait = 0; branch_taken = 1;
        #1;
        checks++;
        if (obs !== IDLE) begin failures++; $display("FAIL reset_branch: obs=%b exp=%b", obs, IDLE); end
`ifdef HCU_PERF_CNT_EN
        checks++;
        if (stall_count !== 0 || flush_count !== 0) begin
            failures++; $display("FAIL reset_cnt: stall=%0d flush=%0d exp=0/0", stall_count, flush_count);
        end
`endif
        @(negedge clk);
        clear_in();
        rst_n = 1;
    endtask

    task automatic test_forwarding();
        settle();
        @(negedge clk);
        clear_in();
        ex_rd = 4'd3; ex_wr = 1; id_rn = 4'd3; id_use_rn = 1;
        #1;
        checks++;
        if (obs !== ctl(1, 0, 0, 1, 1, 1, 0, 0)) begin failures++; $display("FAIL fwd_ex: obs=%b exp=%b", obs, ctl(1, 0, 0, 1, 1, 1, 0, 0)); end
        mem_rd = 4'd3; mem_wr = 1; wb_rd = 4'd3; wb_wr = 1;
        #1;
        checks++;
        if (obs !== ctl(1, 0, 0, 1, 1, 1, 0, 0)) begin failures++; $display("FAIL fwd_ex_prio: obs=%b exp=%b", obs, ctl(1, 0, 0, 1, 1, 1, 0, 0)); end
        clear_in();
        ex_rd = 4'd9; wb_rd = 4'd7; wb_wr = 1; mem_rd = 4'd9; mem_wr = 1;
        id_rm = 4'd7; id_use_rm = 1; id_rd = 4'd9; id_use_rd = 1; id_rn = 4'd9;
        #1;
        checks++;
        if (obs !== ctl(0, 3, 2, 1, 1, 1, 0, 0)) begin failures++; $display("FAIL fwd_mem_wb: obs=%b exp=%b", obs, ctl(0, 3, 2, 1, 1, 1, 0, 0)); end
        mem_wr = 0;
        #1;
        checks++;
        if (obs !== ctl(0, 3, 0, 1, 1, 1, 0, 0)) begin failures++; $display("FAIL fwd_no_wr: obs=%b exp=%b", obs, ctl(0, 3, 0, 1, 1, 1, 0, 0)); end
    endtask

    task automatic test_load_use();
        settle();
        @(negedge clk);
        lu_in();
        #1;
        checks++;
        if (obs !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL lu_stall: obs=%b exp=%b", obs, ctl(0, 1, 0, 0, 0, 0, 0, 0)); end
        @(negedge clk);
        mem_in();
        #1;
        checks++;
        if (obs !== ctl(0, 2, 0, 1, 1, 1, 0, 0)) begin failures++; $display("FAIL lu_resolve: obs=%b exp=%b", obs, ctl(0, 2, 0, 1, 1, 1, 0, 0)); end
    endtask

    task automatic test_lu_mem_wait();
        settle();
        @(negedge clk);
        lu_in();
        #1;
        checks++;
        if (obs !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL lumw_stall: obs=%b exp=%b", obs, ctl(0, 1, 0, 0, 0, 0, 0, 0)); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_in();
            mem_wait = 1;
            #1;
            checks++;
            if (obs !== ctl(0, 2, 0, 1, 0, 0, 0, 1)) begin failures++; $display("FAIL lumw_hold%0d: obs=%b exp=%b", k, obs, ctl(0, 2, 0, 1, 0, 0, 0, 1)); end
        end
        @(negedge clk);
        mem_in();
        #1;
        checks++;
        if (obs !== ctl(0, 2, 0, 1, 1, 1, 0, 0)) begin failures++; $display("FAIL lumw_release: obs=%b exp=%b", obs, ctl(0, 2, 0, 1, 1, 1, 0, 0)); end
        // mem_wait arriving with the hazard: the bubble comes after the hold.
        settle();
        @(negedge clk);
        lu_in();
        mem_wait = 1;
        #1;
        checks++;
        if (obs !== ctl(0, 1, 0, 1, 0, 0, 0, 1)) begin failures++; $display("FAIL lumw_early_hold: obs=%b exp=%b", obs, ctl(0, 1, 0, 1, 0, 0, 0, 1)); end
        @(negedge clk);
        mem_wait = 0;
        #1;
        checks++;
        if (obs !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL lumw_late_stall: obs=%b exp=%b", obs, ctl(0, 1, 0, 0, 0, 0, 0, 0)); end
        @(negedge clk);
        lu_in();
        #1;
        checks++;
        if (obs !== ctl(0, 1, 0, 1, 1, 1, 0, 0)) begin failures++; $display("FAIL lumw_one_bubble: obs=%b exp=%b", obs, ctl(0, 1, 0, 1, 1, 1, 0, 0)); end
    endtask

    task automatic test_branch();
        settle();
        @(negedge clk);
        lu_in();
        branch_taken = 1;
        #1;
        checks++;
        if (obs !== ctl(0, 1, 0, 0, 1, 1, 1, 0)) begin failures++; $display("FAIL br_lu_flush: obs=%b exp=%b", obs, ctl(0, 1, 0, 0, 1, 1, 1, 0)); end
        @(negedge clk);
        clear_in();
        #1;
        checks++;
        if (obs !== IDLE) begin failures++; $display("FAIL br_next: obs=%b exp=%b", obs, IDLE); end
        @(negedge clk);
        clear_in();
        branch_taken = 1; mem_wait = 1;
        #1;
        checks++;
        if (obs !== ctl(0, 0, 0, 1, 0, 0, 0, 1)) begin failures++; $display("FAIL br_mw_hold: obs=%b exp=%b", obs, ctl(0, 0, 0, 1, 0, 0, 0, 1)); end
        @(negedge clk);
        mem_wait = 0;
        #1;
        checks++;
        if (obs !== ctl(0, 0, 0, 0, 1, 1, 1, 0)) begin failures++; $display("FAIL br_mw_release: obs=%b exp=%b", obs, ctl(0, 0, 0, 0, 1, 1, 1, 0)); end
    endtask

    task automatic test_r15();
        settle();
        @(negedge clk);
        clear_in();
        ex_is_load = 1; ex_wr = 1; ex_rd = 4'd15;
        mem_rd = 4'd15; mem_wr = 1; wb_rd = 4'd15; wb_wr = 1;
        id_rn = 4'd15; id_rm = 4'd15; id_rd = 4'd15;
        id_use_rn = 1; id_use_rm = 1; id_use_rd = 1;
        #1;
        checks++;
        if (obs !== IDLE) begin failures++; $display("FAIL r15_no_stall: obs=%b exp=%b", obs, IDLE); end
    endtask

    task automatic test_random();
        settle();
        last_bubble = 0;
`ifdef HCU_PERF_CNT_EN
        @(negedge clk);
        rst_n = 0; #1; rst_n = 1;
        exp_stall = 0; exp_flush = 0;
`endif
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_in();
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 0;
                #1;
                checks++;
                if (obs !== IDLE) begin failures++; $display("FAIL rand_reset%0d: obs=%b exp=%b", i, obs, IDLE); end
                last_bubble = 0;
`ifdef HCU_PERF_CNT_EN
                exp_stall = 0; exp_flush = 0;
`endif
                @(posedge clk);
                #1;
                rst_n = 1;
            end else begin
                exp_v = ref_outputs();
                #1;
                checks++;
                if (obs !== exp_v) begin failures++; $display("FAIL rand_cycle%0d: obs=%b exp=%b", i, obs, exp_v); end
`ifdef HCU_PERF_CNT_EN
                checks++;
                if (stall_count !== 16'(exp_stall) || flush_count !== 16'(exp_flush)) begin
                    failures++;
                    $display("FAIL rand_cnt%0d: stall=%0d flush=%0d exp=%0d/%0d", i, stall_count, flush_count, exp_stall, exp_flush);
                end
                if (!mem_wait && branch_taken) exp_flush++;
                if (!mem_wait && !branch_taken && ref_hazard() && !last_bubble) exp_stall++;
`endif
                if (!mem_wait) last_bubble = !branch_taken && ref_hazard() && !last_bubble;
            end
        end
    endtask

`ifdef HCU_PERF_CNT_EN
    task automatic test_perf();
        settle();
        @(negedge clk);
        rst_n = 0; #1; rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); lu_in();
            @(negedge clk); clear_in();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); clear_in(); branch_taken = 1;
            @(negedge clk); clear_in();
        end
        @(negedge clk); lu_in(); mem_wait = 1;
        @(negedge clk); clear_in();
        @(negedge clk); clear_in(); branch_taken = 1; mem_wait = 1;
        @(negedge clk); clear_in();
        @(negedge clk);
        checks++;
        if (stall_count !== 16'd3 || flush_count !== 16'd2) begin
            failures++; $display("FAIL perf_counts: stall=%0d flush=%0d exp=3/2", stall_count, flush_count);
        end
        lu_in();
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (stall_count !== 0 || flush_count !== 0 || obs !== IDLE) begin
            failures++; $display("FAIL perf_reset: stall=%0d flush=%0d obs=%b exp=0/0 %b", stall_count, flush_count, obs, IDLE);
        end
        @(negedge clk);
        clear_in();
        rst_n = 1;
    endtask
`endif

    initial begin
        clear_in();
        test_reset();
        test_forwarding();
        test_load_use();
        test_lu_mem_wait();
        test_branch();
        test_r15();
`ifdef HCU_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
